serial_port_receiver: RTL

SERIAL_PORT_RECEIVER -- requirements
Module: serial_port_receiver

---
 rtl/serial_port_receiver.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_port_receiver.sv
// serial_port_receiver: 8N1 UART receiver with a small circular receive FIFO
// behind two CPU-readable ports (status and data).
module serial_port_receiver #(
  parameter int         BIT_DURATION_CLOCKS = 500,   // clocks per serial bit (even, >= 8)
  parameter int         FIFO_DEPTH_LOG2     = 2,     // log2 of FIFO entries (>= 1)
  parameter logic [7:0] STATUS_PORT_ID      = 8'h82,
  parameter logic [7:0] DATA_PORT_ID        = 8'h83
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serialPortDataIn,
  input  logic [7:0] cpuPortId,
  input  logic       cpuReadStrobe,
  output logic [7:0] cpuReadData
);

  localparam int TIMER_W    = $clog2(BIT_DURATION_CLOCKS);
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [TIMER_W-1:0]       FULL_BIT_LOAD  = TIMER_W'(BIT_DURATION_CLOCKS - 1);
  localparam logic [TIMER_W-1:0]       HALF_BIT_LOAD  = TIMER_W'(BIT_DURATION_CLOCKS / 2 - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL_CNT  = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Line synchronizer
  logic       sync_meta;
  logic       sync_line;
  logic [1:0] sync_fill;
  logic       line_settled;

  // Receive FSM
  rx_state_t          state;
  rx_state_t          state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [2:0]         bit_index;
  logic [2:0]         bit_index_next;
  logic [7:0]         shift_data;
  logic [7:0]         shift_data_next;
  logic               timer_done;
  logic               push;
  logic               frame_error_set;

  // FIFO and status
  logic [7:0]                 fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       non_empty;
  logic                       full;
  logic                       pop;
  logic                       write_en;
  logic                       overrun_set;
  logic                       status_clear;
  logic                       frame_error;
  logic                       overrun;

  // Two-flop synchronizer on the serial line; sync_fill marks when the
  // synchronizer output reflects the real line again rather than its reset value,
  // so a line held low across reset is not mistaken for an idle-high line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the
    // two-stage synchronizer into a single flop.
    if (reset) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      sync_meta <= serialPortDataIn;
      sync_line <= sync_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  assign line_settled = sync_fill[1];
  assign timer_done   = (timer == '0);

  // FSM state, bit timer, bit index and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_HIGH;
      timer      <= '0;
      bit_index  <= '0;
      shift_data <= '0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      bit_index  <= bit_index_next;
      shift_data <= shift_data_next;
    end
  end

  // Next-state logic: mid-bit sampling, data assembly, stop-bit check
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_next      = state;
    timer_next      = timer;
    bit_index_next  = bit_index;
    shift_data_next = shift_data;
    push            = 1'b0;
    frame_error_set = 1'b0;

    case (state)
      WAIT_HIGH: begin
        if (line_settled && sync_line) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (!sync_line) begin
          state_next = START;
          timer_next = HALF_BIT_LOAD;
        end
      end

      START: begin
        if (timer_done) begin
          if (sync_line) begin
            state_next = IDLE;                // glitch, not a real start bit
          end else begin
            state_next     = DATA;
            timer_next     = FULL_BIT_LOAD;
            bit_index_next = '0;
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end

      DATA: begin
        if (timer_done) begin
          shift_data_next[bit_index] = sync_line;
          timer_next                 = FULL_BIT_LOAD;
          bit_index_next             = bit_index + 3'd1;
          if (bit_index == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end

      STOP: begin
        if (timer_done) begin
          if (sync_line) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_error_set = 1'b1;
            state_next      = WAIT_HIGH;     // line must return high first
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end

      default: begin
        state_next = WAIT_HIGH;
      end
    endcase
  end

  assign non_empty    = (count != '0);
  assign full         = (count == FIFO_FULL_CNT);
  assign pop          = cpuReadStrobe && (cpuPortId == DATA_PORT_ID) && non_empty;
  assign status_clear = cpuReadStrobe && (cpuPortId == STATUS_PORT_ID);
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign write_en     = push && (!full || pop);
  assign overrun_set  = push && full && !pop;

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({write_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the count and pointers
    // define which entries are valid, and an empty FIFO never exposes the array.
    if (write_en) begin
      fifo_mem[wr_ptr] <= shift_data;
    end
  end

  // Sticky error flags: a set event in the same cycle beats a status-read clear
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_error_set) begin
        frame_error <= 1'b1;
      end else if (status_clear) begin
        frame_error <= 1'b0;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (status_clear) begin
        overrun <= 1'b0;
      end
    end
  end

  // CPU read mux
  always_comb begin
    cpuReadData = 8'h00;
    if (cpuPortId == STATUS_PORT_ID) begin
      cpuReadData = {5'b00000, frame_error, overrun, non_empty};
    end else if ((cpuPortId == DATA_PORT_ID) && non_empty) begin
      cpuReadData = fifo_mem[rd_ptr];
    end
  end

endmodule
